// File: rtl/tdm_demux_4to1.sv
// Four-slot TDM receive demultiplexer: tracks slot position from a sync strobe and
// emits all channels in parallel per frame. Optional parity beat: TDM_DEMUX_PARITY_EN.
module tdm_demux_4to1 #(
  parameter int unsigned W = 1
`ifdef TDM_DEMUX_PARITY_EN
  , localparam int unsigned SW = 3
`else
  , localparam int unsigned SW = 2
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  input  logic            in_sync,
  output logic [4*W-1:0]  out_data,
  output logic            out_valid,
  output logic [SW-1:0]   cur_slot,
  output logic            locked,
`ifdef TDM_DEMUX_PARITY_EN
  output logic            sync_err,
  output logic            par_err
`else
  output logic            sync_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned NSH = 4;
`else
  localparam int unsigned NSH = 3;
`endif
  // The final slot of a frame is never buffered; it completes the frame directly.
  localparam logic [SW-1:0] LAST_SLOT = SW'(NSH);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   slot, slot_nx;
  logic [W-1:0]    shadow [NSH];
  logic            wr_en;
  logic [SW-1:0]   wr_idx;
  logic            done, serr;
  logic [4*W-1:0]  frame;
`ifdef TDM_DEMUX_PARITY_EN
  logic            perr;
`endif

  always_comb begin
`ifdef TDM_DEMUX_PARITY_EN
    frame = {shadow[3], shadow[2], shadow[1], shadow[0]};
`else
    frame = {in_data, shadow[2], shadow[1], shadow[0]};
`endif
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    wr_en    = 1'b0;
    wr_idx   = '0;
    done     = 1'b0;
    serr     = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr     = 1'b0;
`endif
    unique case (state)
      HUNT: begin
        if (in_valid && in_sync) begin
          state_nx = LOCKED;
          wr_en    = 1'b1;
          slot_nx  = SW'(1);
        end
      end
      LOCKED: begin
        if (in_valid) begin
          if (in_sync && slot != '0) begin
            // Resync: restart the frame on this beat, dropping the partial one.
            serr    = 1'b1;
            wr_en   = 1'b1;
            slot_nx = SW'(1);
          end else if (slot == LAST_SLOT) begin
            slot_nx = '0;
`ifdef TDM_DEMUX_PARITY_EN
            if (in_data[0] == ^frame) done = 1'b1;
            else                      perr = 1'b1;
`else
            done = 1'b1;
`endif
          end else begin
            wr_en   = 1'b1;
            wr_idx  = slot;
            slot_nx = slot + SW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err   <= 1'b0;
`endif
      for (int unsigned i = 0; i < NSH; i++) shadow[i] <= '0;
    end else begin
      slot      <= slot_nx;
      out_valid <= done;
      sync_err  <= serr;
`ifdef TDM_DEMUX_PARITY_EN
      par_err   <= perr;
`endif
      if (done) out_data <= frame;
      for (int unsigned i = 0; i < NSH; i++)
        if (wr_en && wr_idx == SW'(i)) shadow[i] <= in_data;
    end
  end

  assign cur_slot = slot;
  assign locked   = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4to1.sv
// Scoreboard bench for tdm_demux_4to1 (default 4-beat build, W=1).
module tb_tdm_demux_4to1;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] in_data;
  logic       in_valid;
  logic       in_sync;
  logic [3:0] out_data;
  logic       out_valid;
  logic       locked;
  logic       sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic [2:0] cur_slot;
  logic       par_err;
`else
  logic [1:0] cur_slot;
`endif

  tdm_demux_4to1 #(.W(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .out_data (out_data),
    .out_valid(out_valid),
    .cur_slot (cur_slot),
    .locked   (locked),
`ifdef TDM_DEMUX_PARITY_EN
    .sync_err (sync_err),
    .par_err  (par_err)
`else
    .sync_err (sync_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_serr   = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected frame per out_valid pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) check("unexpected_out_valid", {28'd0, out_data}, 32'hdead);
        else                   check("frame_data", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
      end
      if (sync_err === 1'b1) begin
        n_serr++;
        check("sync_err_with_valid", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  task automatic beat(input logic d, input logic s);
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_data = '0; in_valid = 1'b0; in_sync = 1'b0; rst_n = 1'b1;
    #2;
    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {28'd0, out_data},  32'd0);
    check("rst_locked",    {31'd0, locked},    32'd0);
    check("rst_cur_slot",  {30'd0, cur_slot},  32'd0);
    check("rst_sync_err",  {31'd0, sync_err},  32'd0);

    // Basic frame 0,1,0,1 (ch0 first)
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    exp_q.push_back(4'b1010);
    beat(1'b1, 1'b0);
    check("t1_valid_latency", {31'd0, out_valid}, 32'd1);
    check("t1_locked",        {31'd0, locked},    32'd1);
    idle(2);
    check("t1_valid_single",  {31'd0, out_valid}, 32'd0);
    check("t1_data_hold",     {28'd0, out_data},  32'hA);

    // Unsynced beats in HUNT are discarded
    do_reset();
    beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    check("t2_hunt_locked",   {31'd0, locked},    32'd0);
    check("t2_hunt_slot",     {30'd0, cur_slot},  32'd0);
    beat(1'b1, 1'b1);
    check("t2_slot_after_sync", {30'd0, cur_slot}, 32'd1);
    beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    exp_q.push_back(4'b0001);
    beat(1'b0, 1'b0);

    // Three frames, 2-cycle gap mid-frame 2
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    exp_q.push_back(4'b1111);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1); beat(1'b0, 1'b0);
    idle(2);
    check("t3_gap_slot_hold", {30'd0, cur_slot}, 32'd2);
    beat(1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    exp_q.push_back(4'b0110);
    beat(1'b0, 1'b0);

    // Resync at cur_slot=2
    beat(1'b1, 1'b1); beat(1'b0, 1'b0);
    check("t4_pre_slot", {30'd0, cur_slot}, 32'd2);
    beat(1'b0, 1'b1);
    check("t4_sync_err",  {31'd0, sync_err},  32'd1);
    check("t4_no_valid",  {31'd0, out_valid}, 32'd0);
    check("t4_slot",      {30'd0, cur_slot},  32'd1);
    check("t4_locked",    {31'd0, locked},    32'd1);
    beat(1'b1, 1'b0);
    check("t4_sync_err_pulse", {31'd0, sync_err}, 32'd0);
    beat(1'b1, 1'b0);
    exp_q.push_back(4'b1110);
    beat(1'b1, 1'b0);

    // Reset mid-frame
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_async_locked", {31'd0, locked},   32'd0);
    check("t5_async_slot",   {30'd0, cur_slot}, 32'd0);
    check("t5_async_data",   {28'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    exp_q.push_back(4'b0011);
    beat(1'b0, 1'b0);
    idle(4);

    check("end_queue_empty", exp_q.size(), 32'd0);
    check("end_valid_count", n_valid, 32'd7);
    check("end_sync_err_count", n_serr, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
